// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N-port memory arbiter with bus lock and read-return pipeline; define ARB_ERR_CHECK_EN for the access checker
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_halt,
  input  logic [NUM_PORTS-1:0]    i_req,
  input  logic [NUM_PORTS-1:0]    i_lock,
  input  logic [NUM_PORTS*32-1:0] i_addr,
  input  logic [NUM_PORTS*32-1:0] i_wr_data,
  input  logic [NUM_PORTS*2-1:0]  i_wr_mask,
  input  logic [NUM_PORTS*3-1:0]  i_rd_mask,
  output logic [NUM_PORTS-1:0]    o_gnt,
  output logic [NUM_PORTS-1:0]    o_rd_valid,
  output logic [31:0]             o_rd_data,
  output logic [31:0]             o_mem_addr,
  output logic [31:0]             o_mem_wr_data,
  output logic [1:0]              o_mem_wr_mask,
  output logic [2:0]              o_mem_rd_mask,
`ifdef ARB_ERR_CHECK_EN
  output logic                    o_err,
  output logic [2:0]              o_err_port,
`endif
  input  logic [31:0]             i_mem_rd_data
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int SW = PW + 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] owner, owner_nxt, ptr, ptr_nxt, idx;
  logic [SW-1:0] sum;
  logic hold, gnt_any, bad, fwd;
  logic [31:0] g_addr, g_wdata;
  logic [1:0] g_wm;
  logic [2:0] g_rm;
  logic [RD_LATENCY-1:0] vld;
  logic [RD_LATENCY-1:0][PW-1:0] pid;
  // lock state, lock owner and round-robin pointer
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr <= ptr_nxt;
    end
  end
  // lock is kept while the owner holds i_lock; pointer only moves on unlocked grants
  always_comb begin
    state_nxt = i_halt ? state : (hold || (gnt_any && i_lock[idx])) ? LOCKED : IDLE;
    owner_nxt = (gnt_any && !hold) ? idx : owner;
    ptr_nxt = (gnt_any && !hold) ? ((idx == PW'(NUM_PORTS - 1)) ? '0 : idx + 1'b1) : ptr;
  end
  // grant: the lock owner alone while locked, else first requester at or after ptr
  always_comb begin
    hold = state == LOCKED && i_lock[owner];
    gnt_any = 1'b0;
    idx = owner;
    sum = '0;
    if (hold) gnt_any = i_req[owner];
    else
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        sum = {1'b0, ptr} + SW'(i);
        if (sum >= SW'(NUM_PORTS)) sum = sum - SW'(NUM_PORTS);
        if (i_req[sum[PW-1:0]]) begin
          gnt_any = 1'b1;
          idx = sum[PW-1:0];
        end
      end
    if (i_halt || !i_reset_n) gnt_any = 1'b0;
  end
  assign g_addr = i_addr[32*idx +: 32];
  assign g_wdata = i_wr_data[32*idx +: 32];
  assign g_wm = i_wr_mask[2*idx +: 2];
  assign g_rm = i_rd_mask[3*idx +: 3];
`ifdef ARB_ERR_CHECK_EN
  assign bad = ((g_wm == 2'd2 || g_rm[1:0] == 2'd2) && g_addr[0]) ||
               ((g_wm == 2'd3 || g_rm == 3'd3) && g_addr[1:0] != 2'b00) ||
               g_rm == 3'd4 || g_rm == 3'd7;
  // first offending access is latched until reset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_err <= 1'b0;
      o_err_port <= 3'd0;
    end else if (gnt_any && bad && !o_err) begin
      o_err <= 1'b1;
      o_err_port <= 3'(idx);
    end
  end
`else
  assign bad = 1'b0;
`endif
  assign fwd = gnt_any && !bad;
  assign o_gnt = gnt_any ? NUM_PORTS'(1) << idx : '0;
  assign o_mem_addr = gnt_any ? g_addr : '0;
  assign o_mem_wr_data = gnt_any ? g_wdata : '0;
  assign o_mem_wr_mask = fwd ? g_wm : '0;
  assign o_mem_rd_mask = fwd ? g_rm : '0;
  // read-return pipeline carrying the requesting port ID, frozen during halt
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld <= '0;
      pid <= '0;
    end else if (!i_halt) begin
      vld[0] <= fwd && g_rm != 3'd0;
      pid[0] <= idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end
  assign o_rd_valid = (vld[RD_LATENCY-1] && !i_halt) ? NUM_PORTS'(1) << pid[RD_LATENCY-1] : '0;
  assign o_rd_data = i_mem_rd_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (3 ports, read latency 2)
module tb_mem_port_arbiter;
  localparam int N = 3;
  localparam int L = 2;
  logic clk, rst_n, halt;
  logic [N-1:0] req, lock, gnt, rd_valid;
  logic [N*32-1:0] addr, wdata;
  logic [N*2-1:0] wm;
  logic [N*3-1:0] rm;
  logic [31:0] rd_data, mem_addr, mem_wdata, mem_rd_data;
  logic [1:0] mem_wm;
  logic [2:0] mem_rm;
`ifdef ARB_ERR_CHECK_EN
  logic err;
  logic [2:0] err_port;
`endif
  int checks = 0;
  int errors = 0;
  int uc = 0;
  typedef struct {int port; int due; logic [31:0] data;} rd_t;
  rd_t q[$];
  logic [N-1:0] want, exp_v;
  logic hit;

  mem_port_arbiter #(.NUM_PORTS(N), .RD_LATENCY(L)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_halt(halt), .i_req(req), .i_lock(lock),
    .i_addr(addr), .i_wr_data(wdata), .i_wr_mask(wm), .i_rd_mask(rm),
    .o_gnt(gnt), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_mem_addr(mem_addr), .o_mem_wr_data(mem_wdata), .o_mem_wr_mask(mem_wm), .o_mem_rd_mask(mem_rm),
`ifdef ARB_ERR_CHECK_EN
    .o_err(err), .o_err_port(err_port),
`endif
    .i_mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // unhalted, out-of-reset clock edges: the time base for read return
  always @(posedge clk) if (rst_n && !halt) uc <= uc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : a ^ 32'h5A5A_0000;
  endfunction

  // memory model plus scoreboard: return data when a read falls due and compare
  always @(negedge clk) begin
    hit = q.size() > 0 && rst_n && !halt && q[0].due == uc;
    mem_rd_data = hit ? q[0].data : 32'h0;
    #1;
    exp_v = hit ? N'(1) << q[0].port : '0;
    if (exp_v != 0 || rd_valid != 0) begin
      checks++;
      if (rd_valid !== exp_v) begin
        errors++;
        $display("FAIL rd_valid at uc %0d: got %b want %b", uc, rd_valid, exp_v);
      end
    end
    if (hit) begin
      checks++;
      if (rd_data !== q[0].data) begin
        errors++;
        $display("FAIL rd_data port %0d: got %h want %h", q[0].port, rd_data, q[0].data);
      end
      void'(q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = '0; lock = '0; addr = '0; wdata = '0; wm = '0; rm = '0; halt = 1'b0;
  endtask

  task automatic set_port(input int k, input logic r, input logic lk, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] w, input logic [2:0] rmask);
    req[k] = r; lock[k] = lk; addr[k*32 +: 32] = a; wdata[k*32 +: 32] = d;
    wm[k*2 +: 2] = w; rm[k*3 +: 3] = rmask;
  endtask

  task automatic push_rd(input int k, input logic [31:0] a);
    q.push_back('{port: k, due: uc + L, data: mem_fn(a)});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b0, 32'h40 * k, 32'h0, 2'd0, 3'd3);
    #3;
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt); end
    checks++;
    if (rd_valid !== '0) begin errors++; $display("FAIL reset_rd_valid: got %b want 000", rd_valid); end
    step(); step();
    rst_n = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL idle_gnt: got %b want 000", gnt); end
    checks++;
    if (mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr: got %h want 0", mem_addr); end
    checks++;
    if (mem_rm !== 3'd0 || mem_wm !== 2'd0) begin
      errors++; $display("FAIL idle_masks: got rd %0d wr %0d want 0 0", mem_rm, mem_wm);
    end
    step();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b0, 32'h1000 + 16 * k, 32'hA000 + k, 2'd3, 3'd0);
    for (int c = 0; c < 6; c++) begin
      #2;
      want = N'(1) << (c % N);
      checks++;
      if (gnt !== want) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b want %b", c, gnt, want); end
      checks++;
      if (mem_addr !== 32'h1000 + 16 * (c % N)) begin
        errors++; $display("FAIL rr_addr cycle %0d: got %h want %h", c, mem_addr, 32'h1000 + 16 * (c % N));
      end
      checks++;
      if (mem_wdata !== 32'hA000 + (c % N) || mem_wm !== 2'd3) begin
        errors++; $display("FAIL rr_wdata cycle %0d: got %h/%0d want %h/3", c, mem_wdata, mem_wm, 32'hA000 + (c % N));
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_read();
    set_port(1, 1'b1, 1'b0, 32'h100, 32'h0, 2'd0, 3'd3);
    #2;
    checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL read_gnt: got %b want 010", gnt); end
    checks++;
    if (mem_rm !== 3'd3 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL read_fwd: got mask %0d addr %h want 3 100", mem_rm, mem_addr);
    end
    push_rd(1, 32'h100);
    step();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_read_write();
    set_port(0, 1'b1, 1'b0, 32'h200, 32'h12345678, 2'd3, 3'd3);
    #2;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL rw_gnt: got %b want 001", gnt); end
    checks++;
    if (mem_wm !== 2'd3 || mem_rm !== 3'd3 || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL rw_fwd: got wr %0d rd %0d data %h want 3 3 12345678", mem_wm, mem_rm, mem_wdata);
    end
    push_rd(0, 32'h200);
    step();
    idle_inputs();
    set_port(2, 1'b1, 1'b0, 32'h203, 32'h0, 2'd0, 3'd5);
    #2;
    checks++;
    if (gnt !== 3'b100 || mem_rm !== 3'd5) begin
      errors++; $display("FAIL sbyte_fwd: got gnt %b rd %0d want 100 5", gnt, mem_rm);
    end
    push_rd(2, 32'h203);
    step();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      set_port(2, 1'b1, 1'b0, 32'h300 + 4 * c, 32'h0, 2'd0, 3'd3);
      #2;
      checks++;
      if (gnt !== 3'b100) begin errors++; $display("FAIL b2b_gnt %0d: got %b want 100", c, gnt); end
      push_rd(2, 32'h300 + 4 * c);
      step();
    end
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_lock();
    set_port(0, 1'b1, 1'b1, 32'h400, 32'h1, 2'd3, 3'd0);
    set_port(1, 1'b1, 1'b0, 32'h500, 32'h2, 2'd3, 3'd0);
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (gnt !== 3'b001) begin errors++; $display("FAIL lock_gnt cycle %0d: got %b want 001", c, gnt); end
      step();
    end
    lock[0] = 1'b0;
    #2;
    checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL unlock_gnt: got %b want 010", gnt); end
    step();
    #2;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL post_lock_gnt: got %b want 001", gnt); end
    step();
    idle_inputs();
  endtask

  task automatic test_halt();
    set_port(1, 1'b1, 1'b0, 32'h140, 32'h0, 2'd0, 3'd3);
    #2;
    checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL halt_read_gnt: got %b want 010", gnt); end
    push_rd(1, 32'h140);
    step();
    idle_inputs();
    halt = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h600, 32'h3, 2'd3, 3'd0);
    set_port(2, 1'b1, 1'b0, 32'h700, 32'h4, 2'd3, 3'd0);
    for (int c = 0; c < 5; c++) begin
      #2;
      checks++;
      if (gnt !== '0) begin errors++; $display("FAIL halt_gnt cycle %0d: got %b want 000", c, gnt); end
      step();
    end
    halt = 1'b0;
    #2;
    checks++;
    if (gnt !== 3'b100) begin errors++; $display("FAIL halt_ptr_gnt: got %b want 100", gnt); end
    step();
    idle_inputs();
    repeat (4) step();
  endtask

  task automatic test_reset_mid_read();
    set_port(0, 1'b1, 1'b0, 32'h180, 32'h0, 2'd0, 3'd3);
    #2;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL pre_reset_gnt: got %b want 001", gnt); end
    step();
    rst_n = 1'b0;
    q.delete();
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b0, 32'h800 + 4 * k, 32'h0, 2'd0, 3'd3);
    #2;
    checks++;
    if (gnt !== '0 || rd_valid !== '0) begin
      errors++; $display("FAIL in_reset: got gnt %b valid %b want 000 000", gnt, rd_valid);
    end
    step(); step();
    rst_n = 1'b1;
    #2;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL post_reset_gnt: got %b want 001", gnt); end
    push_rd(0, 32'h800);
    step();
    idle_inputs();
    repeat (4) step();
  endtask

`ifdef ARB_ERR_CHECK_EN
  task automatic test_err();
    set_port(2, 1'b1, 1'b0, 32'h102, 32'h0, 2'd0, 3'd3);
    #2;
    checks++;
    if (gnt !== 3'b100 || mem_rm !== 3'd0) begin
      errors++; $display("FAIL err_fwd: got gnt %b rd %0d want 100 0", gnt, mem_rm);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", err); end
    step();
    idle_inputs();
    checks++;
    if (err !== 1'b1 || err_port !== 3'd2) begin
      errors++; $display("FAIL err_flag: got %b port %0d want 1 2", err, err_port);
    end
    repeat (4) step();
  endtask
`endif

  initial begin
    mem_rd_data = 32'h0;
    test_reset();
    test_round_robin();
    test_read();
    test_read_write();
    test_back_to_back();
    test_lock();
    test_halt();
    test_reset_mid_read();
`ifdef ARB_ERR_CHECK_EN
    test_err();
`endif
    repeat (4) step();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL reads_outstanding: got %0d want 0", q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
